mosaic_pixel_hold: RTL and testbench
====================================

Name: mosaic_pixel_hold

Overview:
- Output-side counterpart of the mosaic coordinate snapping: consumes the raw BG pixel stream in raster order and applies mosaic by holding and replaying pixel values.
- Holds the pixel at each horizontal block origin across the block width.
- Replays a line buffer of the vertical block-origin row for the remaining rows of that block.
- Sits between the BG pixel fetch/palette stage and the layer priority mixer, one instance per BG layer.

Parameters:
- H_PIXELS, 240, visible pixels per line; column counter wraps here.
- V_LINES, 160, visible lines per frame; row counter wraps here.
- PIX_W, 16, pixel width: bit 15 transparent flag, bits 14:0 BGR555 colour.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- frame_start  input  1  one-cycle pulse; next accepted pixel is row 0, col 0
- mosaic  input  1  mosaic enable for this layer
- hscale  input  4  horizontal mosaic size minus 1
- vscale  input  4  vertical mosaic size minus 1
- in_valid  input  1  in_pixel valid
- in_ready  output  1  block can accept in_pixel this cycle
- in_pixel  input  PIX_W  raw pixel, raster order
- out_valid  output  1  out_pixel valid
- out_ready  input  1  downstream accepts out_pixel
- out_pixel  output  PIX_W  mosaiced pixel
- out_row  output  10  row of out_pixel
- out_col  output  10  column of out_pixel

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: out_valid=0, out_pixel=0, out_row=0, out_col=0. Internal col, row, hcnt, vcnt, hold and latched scales are all 0.
- in_ready = !out_valid || out_ready.
- Accept occurs when in_valid && in_ready. Each accept loads the output register, so latency is exactly 1 cycle from accept to out_valid.
- Output hold: out_valid && !out_ready keeps out_pixel, out_row and out_col stable.
- If there is no accept and out_ready=1, out_valid drops to 0.
- Scale latch: at each accept with col=0 and row=0, latch hmod=(mosaic?hscale:0)+1 and vmod=(mosaic?vscale:0)+1 (5-bit). These are used for the entire frame. Scale changes mid-frame have no effect until the next frame's first pixel.
  - The first pixel of a frame uses the newly latched values.
- Counters (advance on accept):
  - col increments and wraps H_PIXELS-1 -> 0.
  - On col wrap, row increments and wraps V_LINES-1 -> 0.
  - hcnt counts 0..hmod-1, resets to 0 on col wrap.
  - vcnt counts 0..vmod-1, resets to 0 on row wrap.
- Pixel selection per accept:
  - Vertical origin row (vcnt==0):
    - If hcnt==0: result=in_pixel and hold<=in_pixel.
    - Else: result=hold.
    - In both cases linebuf[col]<=result.
  - Other rows (vcnt!=0): result=linebuf[col]; in_pixel is consumed and discarded.
- out_row/out_col carry the unsnapped row/col of the accepted pixel.
- Block truncation: a block cut off at col H_PIXELS-1 or row V_LINES-1 is simply truncated. The next line or frame restarts at hcnt=0 / vcnt=0.
- frame_start:
  - Forces col=row=hcnt=vcnt=0 for the next accept.
  - If it coincides with an accept, that accepted pixel is treated as row 0, col 0 and the counters advance from there.
  - frame_start does not clear out_valid; a pending output still drains.
- Line buffer: H_PIXELS x PIX_W, with combinational read and synchronous write. Read and write of the same address in the same accept never occur, because a row either writes or reads.
- Mosaic disabled (hmod=vmod=1): output equals input, delayed 1 cycle.
- Reset mid-frame: all state returns to reset values. Line buffer contents are don't-care, because a row-0 accept rewrites them before any read.

Test Plan:
- Passthrough: mosaic=0, frame_start, stream pixel=col+row*H for a full frame with out_ready=1 -> out_pixel equals input one cycle later, and out_row/out_col match.
- Horizontal mosaic: mosaic=1, hscale=3, vscale=0, row 0 inputs 0x0000..0x00EF -> outputs 0,0,0,0,4,4,4,4,...
  - Last block: cols 236..239 give 0x00EC.
- Vertical mosaic: hscale=1, vscale=2 -> rows 1–2 outputs equal row 0 outputs (col pairs snapped) regardless of input; row 3 takes fresh input.
  - Truncation: row 159 replays row 159 (159%3=0) data.
- Backpressure: hold out_ready=0 for 5 cycles mid-line with in_valid=1 -> in_ready=0, output stable, no pixel lost or duplicated, hcnt unaffected.
- Scale change mid-frame: set hscale 3->1 at row 50 -> frame continues with size 4; the next frame, after frame_start, uses size 2.
- Reset at row 10 col 100 with reset_n low 1 cycle -> out_valid=0 next cycle; after frame_start, outputs are correct from row 0 col 0.

Source files
------------

// File: rtl/mosaic_pixel_hold_if.sv
// Pixel stream bundle for mosaic_pixel_hold: raster input, mosaiced output and
// the per-layer mosaic controls.
interface mosaic_pixel_hold_if #(
  parameter int PIX_W = 16
);
  logic             frame_start;
  logic             mosaic;
  logic [3:0]       hscale;
  logic [3:0]       vscale;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic [9:0]       out_row;
  logic [9:0]       out_col;

  modport master (
    output frame_start, mosaic, hscale, vscale, in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_row, out_col
  );

  modport slave (
    input  frame_start, mosaic, hscale, vscale, in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_row, out_col
  );
endinterface

// File: rtl/mosaic_pixel_hold.sv
// BG-layer mosaic: holds the block-origin pixel across each block horizontally
// and replays the block-origin row from a line buffer for the rows below it.
module mosaic_pixel_hold #(
  parameter int H_PIXELS = 240,
  parameter int V_LINES  = 160,
  parameter int PIX_W    = 16
) (
  input  logic clock,
  input  logic reset_n,
  mosaic_pixel_hold_if.slave bus
);

  localparam int         AW       = $clog2(H_PIXELS);
  localparam logic [9:0] COL_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_LINES - 1);

  logic [9:0]       col, row;
  logic [4:0]       hcnt, vcnt, hmod, vmod;
  logic [PIX_W-1:0] hold;
  logic [PIX_W-1:0] linebuf [H_PIXELS];

  logic             vld_p0;
  logic [PIX_W-1:0] pix_p0;
  logic [9:0]       row_p0, col_p0;

  logic             accept;
  logic [9:0]       c_eff, r_eff, col_nx, row_nx;
  logic [4:0]       hc_eff, vc_eff, hm_eff, vm_eff, hc_nx, vc_nx;
  logic             first, origin, col_wrap, row_wrap;
  logic [PIX_W-1:0] result;

  assign bus.in_ready  = !vld_p0 || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_p0;
  assign bus.out_pixel = pix_p0;
  assign bus.out_row   = row_p0;
  assign bus.out_col   = col_p0;

  // frame_start coinciding with an accept makes that pixel row 0 / col 0,
  // and the first pixel of a frame already sees the freshly latched scales.
  always_comb begin
    c_eff    = bus.frame_start ? 10'd0 : col;
    r_eff    = bus.frame_start ? 10'd0 : row;
    hc_eff   = bus.frame_start ? 5'd0  : hcnt;
    vc_eff   = bus.frame_start ? 5'd0  : vcnt;
    first    = (c_eff == 10'd0) && (r_eff == 10'd0);
    hm_eff   = first ? ({1'b0, bus.mosaic ? bus.hscale : 4'd0} + 5'd1) : hmod;
    vm_eff   = first ? ({1'b0, bus.mosaic ? bus.vscale : 4'd0} + 5'd1) : vmod;
    origin   = (vc_eff == 5'd0);
    result   = linebuf[c_eff[AW-1:0]];
    if (origin) begin
      result = (hc_eff == 5'd0) ? bus.in_pixel : hold;
    end
    col_wrap = (c_eff == COL_LAST);
    row_wrap = col_wrap && (r_eff == ROW_LAST);
    col_nx   = col_wrap ? 10'd0 : c_eff + 10'd1;
    row_nx   = r_eff;
    if (col_wrap) begin
      row_nx = (r_eff == ROW_LAST) ? 10'd0 : r_eff + 10'd1;
    end
    hc_nx    = (col_wrap || (hc_eff == 5'(hm_eff - 5'd1))) ? 5'd0 : hc_eff + 5'd1;
    vc_nx    = vc_eff;
    if (row_wrap) begin
      vc_nx = 5'd0;
    end else if (col_wrap) begin
      vc_nx = (vc_eff == 5'(vm_eff - 5'd1)) ? 5'd0 : vc_eff + 5'd1;
    end
  end

  // Stage p0: output register, counters and origin-pixel hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= '0;
      hcnt   <= '0;
      vcnt   <= '0;
      hmod   <= '0;
      vmod   <= '0;
      hold   <= '0;
      vld_p0 <= 1'b0;
      pix_p0 <= '0;
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (accept) begin
      col    <= col_nx;
      row    <= row_nx;
      hcnt   <= hc_nx;
      vcnt   <= vc_nx;
      if (first) begin
        hmod <= hm_eff;
        vmod <= vm_eff;
      end
      if (origin && (hc_eff == 5'd0)) begin
        hold <= bus.in_pixel;
      end
      vld_p0 <= 1'b1;
      pix_p0 <= result;
      row_p0 <= r_eff;
      col_p0 <= c_eff;
    end else begin
      if (bus.frame_start) begin
        col  <= '0;
        row  <= '0;
        hcnt <= '0;
        vcnt <= '0;
      end
      if (bus.out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // Origin rows record what they emitted; the rows below replay it.
  always_ff @(posedge clock) begin
    if (accept && origin) begin
      linebuf[c_eff[AW-1:0]] <= result;
    end
  end

endmodule

// File: tb/tb_mosaic_pixel_hold.sv
// Directed bench for mosaic_pixel_hold: passthrough, reset, horizontal and
// vertical mosaic, backpressure, mid-frame scale change and frame wrap.
module tb_mosaic_pixel_hold;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  mosaic_pixel_hold_if #(.PIX_W(16)) bus ();

  mosaic_pixel_hold #(.H_PIXELS(240), .V_LINES(160), .PIX_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] pix(input int r, input int c);
    return 16'(r * 240 + c);
  endfunction

  function automatic logic [37:0] pack(input logic rdy, input logic vld,
                                       input logic [15:0] p, input int r, input int c);
    return {rdy, vld, p, 10'(r), 10'(c)};
  endfunction

  function automatic logic [37:0] observed();
    return {bus.in_ready, bus.out_valid, bus.out_pixel, bus.out_row, bus.out_col};
  endfunction

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One accepted pixel; output is sampled 1 time unit after the accepting edge.
  task automatic push(input string tag, input logic [15:0] p, input logic fs,
                      input logic [15:0] ep, input int er, input int ec);
    bus.in_valid    = 1'b1;
    bus.in_pixel    = p;
    bus.frame_start = fs;
    @(posedge clock);
    #1;
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    check(tag, observed(), pack(1'b1, 1'b1, ep, er, ec));
  endtask

  task automatic idle_frame_start(input logic fs);
    bus.in_valid    = 1'b0;
    bus.frame_start = fs;
    @(posedge clock);
    #1;
    bus.frame_start = 1'b0;
    check("idle_drop", {36'd0, bus.in_ready, bus.out_valid}, {36'd0, 2'b10});
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.mosaic      = 1'b0;
    bus.hscale      = 4'd0;
    bus.vscale      = 4'd0;
    bus.in_valid    = 1'b0;
    bus.in_pixel    = '0;
    bus.out_ready   = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("reset_state", observed(), pack(1'b1, 1'b0, 16'h0000, 0, 0));
    reset_n = 1'b1;

    // Passthrough with scales present but mosaic off, up to row 10 col 100.
    bus.hscale = 4'd5;
    bus.vscale = 4'd7;
    idle_frame_start(1'b1);
    for (int r = 0; r <= 10; r++) begin
      for (int c = 0; c < 240; c++) begin
        if (r == 10 && c > 100) break;
        push("pass_a", pix(r, c) ^ 16'h8000, 1'b0, pix(r, c) ^ 16'h8000, r, c);
      end
    end

    // Mid-frame reset for one cycle.
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("midframe_reset", observed(), pack(1'b1, 1'b0, 16'h0000, 0, 0));

    idle_frame_start(1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 240; c++)
        push("pass_b", pix(r, c), 1'b0, pix(r, c), r, c);
    idle_frame_start(1'b0);

    // Horizontal mosaic of 4, with backpressure on row 1 and a scale change at row 50.
    bus.mosaic = 1'b1;
    bus.hscale = 4'd3;
    bus.vscale = 4'd0;
    idle_frame_start(1'b1);
    for (int r = 0; r <= 50; r++) begin
      if (r == 50) bus.hscale = 4'd1;
      for (int c = 0; c < 240; c++) begin
        if (r == 1 && c == 100) begin
          bus.out_ready = 1'b0;
          bus.in_valid  = 1'b1;
          bus.in_pixel  = pix(1, 100);
          for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check("backpressure", observed(), pack(1'b0, 1'b1, pix(1, 96), 1, 99));
          end
          bus.out_ready = 1'b1;
        end
        push("hmosaic", pix(r, c), 1'b0, pix(r, c - c % 4), r, c);
      end
    end

    // Next frame: frame_start on the first accept, 2x3 blocks, junk on replay rows.
    bus.vscale = 4'd2;
    for (int r = 0; r < 160; r++) begin
      for (int c = 0; c < 240; c++) begin
        push("vmosaic",
             (r % 3 == 0) ? pix(r, c) : (16'hDEAD ^ 16'(c)),
             (r == 0 && c == 0),
             pix(r - r % 3, c - c % 2), r, c);
      end
    end

    // Natural frame wrap restarts at a fresh origin row.
    push("frame_wrap", 16'h1234, 1'b0, 16'h1234, 0, 0);
    push("frame_wrap", 16'h5678, 1'b0, 16'h1234, 0, 1);
    idle_frame_start(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
